data_mem_responder: RTL and testbench

Data-memory responder on the far side of the memory-access (MA) stage interface: accepts one load or store request at a time from the MA stage, holds it for a fixed number of wait states, commits stores, and returns load data with a one-cycle response pulse. It sits between the MA stage and the word-addressed data RAM. While it is busy it tells the pipeline to stall MA and everything upstream.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t : responder FSM states
//   WORD_W  : data word width
//   OFFS_W  : byte-offset width inside a word
//   CNT_W   : wait-state counter width
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int OFFS_W = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MA stage and the data-memory responder.
//   master : MA stage side (drives the request, observes the response/stall)
//   slave  : responder side
interface data_mem_responder_if;

    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [dmem_pkg::WORD_W-1:0] req_addr;
    logic [dmem_pkg::WORD_W-1:0] req_wdata;
    logic                        resp_valid;
    logic [dmem_pkg::WORD_W-1:0] resp_rdata;
    logic                        resp_err;
    logic                        mem_busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_busy
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous data RAM, DEPTH_WORDS x WORD_W.
//   clk   : rising-edge clock
//   en    : access enable (write when we=1, read otherwise)
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, updated only on enabled reads
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder behind the MA stage. Accepts one load/store at a time,
// holds it for LATENCY wait states, commits stores / reads loads on the edge
// entering RESP, and signals completion with a one-cycle resp_valid pulse.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of the MA request/response bus
// Parameters: DEPTH_WORDS (power of two), LATENCY (0..15 wait states).
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting wait states
// RESP  | one-cycle response with data/error
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [WORD_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic               err_q;

    logic               accept;
    logic               cur_we;
    logic [WORD_W-1:0]  cur_addr;
    logic [WORD_W-1:0]  cur_wdata;
    logic               cur_err;
    logic               ram_en;
    logic [WORD_W-1:0]  ram_rdata;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With LATENCY=0 the RAM access happens on the accept edge itself, before
    // the latches hold anything, so the live bus is used while in IDLE.
    assign cur_we    = (state_q == IDLE) ? bus.req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

    assign cur_err = (cur_addr[OFFS_W-1:0] != '0)
                  || (cur_addr[WORD_W-1:OFFS_W] >= (WORD_W - OFFS_W)'(DEPTH_WORDS));

    // RAM is touched only on the edge entering RESP; reset aborts the access.
    assign ram_en = !reset && (state_d == RESP) && !cur_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_d == RESP) begin
                err_q <= cur_err;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (cur_we),
        .addr  (cur_addr[ADDR_W+OFFS_W-1:OFFS_W]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.mem_busy   = (state_q != IDLE);
    // Read data register is not reset, so it is masked outside a clean load response.
    assign bus.resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    bit [31:0] mdl [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    function automatic bit exp_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 32'(DEPTH));
    endfunction

    // Issues one request on the LATENCY=2 instance and records what was seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output bit acc, output int resp_k, output int pulses,
                          output bit busy_ok, output logic [31:0] rdata, output logic err);
        int n;
        n = 0;
        acc = 0; resp_k = -1; pulses = 0; busy_ok = 1; rdata = '0; err = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.mem_busy !== (k <= LAT + 1)) busy_ok = 0;
            if (bus.resp_valid === 1'b1) begin
                pulses++;
                if (resp_k < 0) begin
                    resp_k = k; rdata = bus.resp_rdata; err = bus.resp_err;
                end
            end else if (bus.resp_valid !== 1'b0) begin
                pulses += 100;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        tests++; if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.resp_rdata); end
        tests++; if (bus.resp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.resp_err); end
        tests++; if (bus.mem_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.mem_busy); end
        tests++; if (bus0.req_ready !== 1'b1 || bus0.mem_busy !== 1'b0) begin
            fails++; $display("FAIL reset_lat0: ready %b busy %b expected 1 0", bus0.req_ready, bus0.mem_busy);
        end
    endtask

    task automatic test_preload_load();
        bit acc; int rk, pul; bit bok; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, acc, rk, pul, bok, rd, er);
        mdl[4] = 32'hDEADBEEF;
        tests++; if (!acc || er !== 1'b0 || rd !== 32'h0) begin
            fails++; $display("FAIL preload_store: acc %0d err %b rdata %h expected 1 0 0", acc, er, rd);
        end
        do_req(1'b0, 32'h10, 32'h0, acc, rk, pul, bok, rd, er);
        tests++; if (rk !== LAT + 1 || pul !== 1) begin
            fails++; $display("FAIL load_latency: resp at %0d pulses %0d expected %0d 1", rk, pul, LAT + 1);
        end
        tests++; if (!bok) begin fails++; $display("FAIL load_busy: busy window wrong, expected cycles 1..%0d", LAT + 1); end
        tests++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            fails++; $display("FAIL load_data: got %h err %b expected deadbeef 0", rd, er);
        end
    endtask

    task automatic test_store_load();
        int acc_at [2];
        int idx, n, rk;
        logic [31:0] rd; logic er;
        idx = 0; n = 0; rk = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
        while (idx < 2 && n < 30) begin
            if (bus.req_ready === 1'b1) begin
                @(posedge clk);
                #1 acc_at[idx] = cyc;
                idx++;
                @(negedge clk);
                if (idx == 1) begin
                    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
                n++;
            end
        end
        mdl[8] = 32'h12345678;
        for (int k = 1; k <= LAT + 3; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.resp_valid === 1'b1 && rk < 0) begin
                rk = k; rd = bus.resp_rdata; er = bus.resp_err;
            end
        end
        tests++; if (idx != 2) begin fails++; $display("FAIL b2b_accepts: got %0d expected 2", idx); end
        tests++; if (idx == 2 && (acc_at[1] - acc_at[0]) != LAT + 2) begin
            fails++; $display("FAIL b2b_spacing: got %0d expected %0d", acc_at[1] - acc_at[0], LAT + 2);
        end
        tests++; if (rk != LAT + 1 || rd !== 32'h12345678 || er !== 1'b0) begin
            fails++; $display("FAIL store_then_load: at %0d got %h err %b expected %0d 12345678 0", rk, rd, er, LAT + 1);
        end
    endtask

    task automatic test_misaligned();
        bit acc; int rk, pul; bit bok; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h22, 32'hFFFFFFFF, acc, rk, pul, bok, rd, er);
        tests++; if (er !== 1'b1 || rk != LAT + 1) begin
            fails++; $display("FAIL misaligned_err: got %b at %0d expected 1 at %0d", er, rk, LAT + 1);
        end
        do_req(1'b0, 32'h20, 32'h0, acc, rk, pul, bok, rd, er);
        tests++; if (rd !== 32'h12345678 || er !== 1'b0) begin
            fails++; $display("FAIL misaligned_nowrite: got %h err %b expected 12345678 0", rd, er);
        end
    endtask

    task automatic test_out_of_range();
        bit acc; int rk, pul; bit bok; logic [31:0] rd; logic er;
        do_req(1'b0, 32'(DEPTH * 4), 32'h0, acc, rk, pul, bok, rd, er);
        tests++; if (er !== 1'b1 || rd !== 32'h0 || rk != LAT + 1) begin
            fails++; $display("FAIL oor_load: err %b rdata %h at %0d expected 1 0 at %0d", er, rd, rk, LAT + 1);
        end
        do_req(1'b1, 32'((DEPTH - 1) * 4), 32'hCAFE0001, acc, rk, pul, bok, rd, er);
        mdl[DEPTH - 1] = 32'hCAFE0001;
        do_req(1'b0, 32'((DEPTH - 1) * 4), 32'h0, acc, rk, pul, bok, rd, er);
        tests++; if (er !== 1'b0 || rd !== 32'hCAFE0001) begin
            fails++; $display("FAIL top_word: err %b rdata %h expected 0 cafe0001", er, rd);
        end
    endtask

    task automatic test_reset_in_wait();
        bit acc; int rk, pul; bit bok; logic [31:0] rd; logic er;
        int seen;
        do_req(1'b1, 32'h30, 32'hA5A5_0030, acc, rk, pul, bok, rd, er);
        mdl[12] = 32'hA5A5_0030;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'h5A5A_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests++; if (bus.mem_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
            fails++; $display("FAIL wait_state: busy %b ready %b expected 1 0", bus.mem_busy, bus.req_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (bus.req_ready !== 1'b1 || bus.mem_busy !== 1'b0) begin
            fails++; $display("FAIL reset_abort_idle: ready %b busy %b expected 1 0", bus.req_ready, bus.mem_busy);
        end
        seen = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            if (bus.resp_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL reset_abort_resp: got %0d pulses expected 0", seen); end
        do_req(1'b0, 32'h30, 32'h0, acc, rk, pul, bok, rd, er);
        tests++; if (rd !== 32'hA5A5_0030 || er !== 1'b0) begin
            fails++; $display("FAIL reset_abort_data: got %h expected a5a50030", rd);
        end
    endtask

    task automatic test_random();
        bit acc; int rk, pul; bit bok; logic [31:0] rd; logic er;
        logic [31:0] a, wd, exp_rd;
        logic we;
        bit e, known;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
            else if (sel == 6) a = 32'((DEPTH - 1) * 4);
            else if (sel == 7) a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 15));
            else               a = $urandom | 32'h8000_0000;
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            e = exp_err(a);
            known = !e && mdl.exists(int'(a / 4));
            exp_rd = (!we && known) ? mdl[int'(a / 4)] : 32'h0;
            do_req(we, a, wd, acc, rk, pul, bok, rd, er);
            if (we && !e) mdl[int'(a / 4)] = wd;
            tests++; if (!acc || rk != LAT + 1 || pul != 1 || !bok) begin
                fails++; $display("FAIL rnd_timing[%0d]: acc %0d resp at %0d pulses %0d busy_ok %0d expected 1 %0d 1 1",
                                  i, acc, rk, pul, bok, LAT + 1);
            end
            tests++; if (er !== e) begin
                fails++; $display("FAIL rnd_err[%0d]: addr %h got %b expected %b", i, a, er, e);
            end
            if (we || e || known) begin
                tests++; if (rd !== exp_rd) begin
                    fails++; $display("FAIL rnd_rdata[%0d]: addr %h we %b got %h expected %h", i, a, we, rd, exp_rd);
                end
            end
        end
    endtask

    task automatic test_lat0();
        logic [31:0] adr [6];
        logic [31:0] dat [6];
        int prev_acc, acc_now;
        prev_acc = 0;
        for (int i = 0; i < 3; i++) begin
            adr[i] = 32'h200 + 32'(8 * i);
            dat[i] = $urandom;
            adr[i + 3] = adr[i];
            dat[i + 3] = 32'h0;
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = adr[0]; bus0.req_wdata = dat[0];
            end
            tests++; if (bus0.req_ready !== 1'b1 || bus0.mem_busy !== 1'b0 || bus0.resp_valid !== 1'b0) begin
                fails++; $display("FAIL lat0_idle[%0d]: ready %b busy %b resp %b expected 1 0 0",
                                  i, bus0.req_ready, bus0.mem_busy, bus0.resp_valid);
            end
            @(posedge clk);
            #1 acc_now = cyc;
            if (i > 0) begin
                tests++; if (acc_now - prev_acc != 2) begin
                    fails++; $display("FAIL lat0_spacing[%0d]: got %0d expected 2", i, acc_now - prev_acc);
                end
            end
            prev_acc = acc_now;
            @(negedge clk);
            tests++; if (bus0.resp_valid !== 1'b1 || bus0.mem_busy !== 1'b1 || bus0.req_ready !== 1'b0
                         || bus0.resp_err !== 1'b0) begin
                fails++; $display("FAIL lat0_resp[%0d]: resp %b busy %b ready %b err %b expected 1 1 0 0",
                                  i, bus0.resp_valid, bus0.mem_busy, bus0.req_ready, bus0.resp_err);
            end
            if (i >= 3) begin
                tests++; if (bus0.resp_rdata !== dat[i - 3]) begin
                    fails++; $display("FAIL lat0_rdata[%0d]: got %h expected %h", i, bus0.resp_rdata, dat[i - 3]);
                end
            end
            if (i < 5) begin
                bus0.req_we = (i + 1) < 3; bus0.req_addr = adr[i + 1]; bus0.req_wdata = dat[i + 1];
            end else begin
                bus0.req_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        test_reset();
        test_preload_load();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_reset_in_wait();
        test_random();
        test_lat0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
